// File: rtl/ti83p_keypad_if.sv
// rtl/ti83p_keypad_if.sv - CPU keypad-port bus: group-mask write and column-data read.
interface ti83p_keypad_if;
   logic       grp_we;
   logic [6:0] grp_mask;
   logic [7:0] key_data;
   logic       key_busy;

   modport master (output grp_we, grp_mask, input key_data, key_busy);
   modport slave  (input grp_we, grp_mask, output key_data, key_busy);
endinterface

// File: rtl/ti83p_keypad.sv
// rtl/ti83p_keypad.sv - PS/2 key events to TI-83+ 7x8 keypad matrix and ON key,
// with a settling window after each group-mask write.
module ti83p_keypad #(
   parameter int SETTLE_CYCLES = 8,
   parameter int CNT_W         = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [10:0]     ps2_key,
   ti83p_keypad_if.slave   cpu,
   output logic            on_key,
   output logic            on_edge,
   output logic            any_key
);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
   localparam bit               SETTLE_ON = (SETTLE_CYCLES != 0);

   logic [6:0][7:0] row;
   logic [6:0]      grp;
   logic [CNT_W-1:0] cnt;
   logic [7:0]      data_q;
   logic            busy_q;
   logic            primed;
   logic            prev_toggle;

   logic            key_event;
   logic            settling;
   logic [7:0]      sel_or;
   logic [6:0]      map;      // {hit, group, column}
   logic            hit_on;

   assign cpu.key_data = data_q;
   assign cpu.key_busy = busy_q;

   assign key_event = primed && (ps2_key[10] != prev_toggle);
   assign settling  = (cpu.grp_we && SETTLE_ON) || (cnt != '0);

   always_comb begin
      map    = 7'd0;
      hit_on = 1'b0;
      case ({ps2_key[8], ps2_key[7:0]})
         9'h172: map = {1'b1, 3'd0, 3'd0};
         9'h16B: map = {1'b1, 3'd0, 3'd1};
         9'h174: map = {1'b1, 3'd0, 3'd2};
         9'h175: map = {1'b1, 3'd0, 3'd3};
         9'h05A, 9'h15A: map = {1'b1, 3'd1, 3'd0};
         9'h079: map = {1'b1, 3'd1, 3'd1};
         9'h07B: map = {1'b1, 3'd1, 3'd2};
         9'h07C: map = {1'b1, 3'd1, 3'd3};
         9'h14A: map = {1'b1, 3'd1, 3'd4};
         9'h00E: map = {1'b1, 3'd1, 3'd5};
         9'h076: map = {1'b1, 3'd1, 3'd6};
         9'h04E: map = {1'b1, 3'd2, 3'd0};
         9'h026: map = {1'b1, 3'd2, 3'd1};
         9'h036: map = {1'b1, 3'd2, 3'd2};
         9'h046: map = {1'b1, 3'd2, 3'd3};
         9'h049: map = {1'b1, 3'd3, 3'd0};
         9'h01E: map = {1'b1, 3'd3, 3'd1};
         9'h02E: map = {1'b1, 3'd3, 3'd2};
         9'h03E: map = {1'b1, 3'd3, 3'd3};
         9'h045: map = {1'b1, 3'd4, 3'd0};
         9'h016: map = {1'b1, 3'd4, 3'd1};
         9'h025: map = {1'b1, 3'd4, 3'd2};
         9'h03D: map = {1'b1, 3'd4, 3'd3};
         9'h041: map = {1'b1, 3'd4, 3'd4};
         9'h014: map = {1'b1, 3'd5, 3'd7};
         9'h005: map = {1'b1, 3'd6, 3'd4};
         9'h006: map = {1'b1, 3'd6, 3'd3};
         9'h004: map = {1'b1, 3'd6, 3'd2};
         9'h00C: map = {1'b1, 3'd6, 3'd1};
         9'h003: map = {1'b1, 3'd6, 3'd0};
         9'h012: map = {1'b1, 3'd6, 3'd5};
         9'h066: map = {1'b1, 3'd6, 3'd7};
         9'h007: hit_on = 1'b1;
         default: map = 7'd0;
      endcase
   end

   // Active-low read: a column reads 0 if any selected group has that key down.
   always_comb begin
      sel_or = 8'h00;
      for (int g = 0; g < 7; g++) begin
         if (!grp[g]) sel_or = sel_or | row[g];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row         <= '0;
         grp         <= 7'h7F;
         cnt         <= '0;
         data_q      <= 8'hFF;
         busy_q      <= 1'b0;
         on_key      <= 1'b0;
         on_edge     <= 1'b0;
         any_key     <= 1'b0;
         primed      <= 1'b0;
         prev_toggle <= 1'b0;
      end else begin
         on_edge <= 1'b0;
         // The toggle level seen at start-up is a baseline, not a key event.
         if (!primed) begin
            primed      <= 1'b1;
            prev_toggle <= ps2_key[10];
         end else if (key_event) begin
            prev_toggle <= ps2_key[10];
            if (hit_on) begin
               on_edge <= ps2_key[9] && !on_key;
               on_key  <= ps2_key[9];
            end else if (map[6]) begin
               row[map[5:3]][map[2:0]] <= ps2_key[9];
            end
         end
         any_key <= |row;
         if (cpu.grp_we) begin
            grp <= cpu.grp_mask;
            cnt <= SETTLE_LD;
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         busy_q <= settling;
         data_q <= settling ? 8'hFF : ~sel_or;
      end
   end
endmodule

// File: doc/ti83p_keypad.md
Name: ti83p_keypad

Overview:
- Converts MiSTer `ps2_key` events from hps_io into the TI-83+ 7×8 keypad matrix plus the separate ON key.
- Serves CPU keypad-port accesses: the CPU writes an active-low group mask and reads active-low column data.
- Sits between hps_io and the calculator core inside emu, directly upstream of the core's port-1 logic.
- Models the real keypad's settling delay after a group-mask write.

Parameters:
- SETTLE_CYCLES, 8: clk cycles after a mask write during which key_data reads 8'hFF; 0 disables the delay.
- CNT_W, 8: width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk       in   1   system clock (clk_sys)
- reset     in   1   asynchronous, active-high reset
- ps2_key   in   11  [10]=event toggle, [9]=pressed, [8]=extended (E0), [7:0]=scancode
- grp_we    in   1   one-cycle strobe: CPU write to keypad port
- grp_mask  in   7   active-low group select; bit g=0 selects group g
- key_data  out  8   active-low column data: AND of selected groups' rows
- key_busy  out  1   high while settle countdown is running
- on_key    out  1   level: ON key held
- on_edge   out  1   one-cycle pulse on ON press (to interrupt logic)
- any_key   out  1   level: any matrix key held

Behaviour:
- Reset is asynchronous, active-high. Values under reset:
  - matrix: all 56 bits released
  - grp latch: 7'h7F
  - key_data: 8'hFF
  - key_busy: 0
  - on_key, on_edge, any_key: 0
  - settle counter: 0
  - primed: 0
- First clk edge after reset deassertion: capture ps2_key[10] into prev_toggle and set primed=1. No event is processed on this edge.
- Event detect: primed && ps2_key[10] != prev_toggle. On that edge, update prev_toggle and apply the event. Press (bit9=1) sets the mapped matrix bit; release (bit9=0) clears it.
- Unmapped codes are ignored, but prev_toggle still updates.
- Key map (group,bit; E0 = extended):
  - E0 72 → (0,0) down; E0 6B → (0,1) left; E0 74 → (0,2) right; E0 75 → (0,3) up
  - 5A or E0 5A → (1,0) ENTER
  - 79 → (1,1) +; 7B → (1,2) −; 7C → (1,3) ×; E0 4A → (1,4) ÷
  - 0E → (1,5) ^; 76 → (1,6) CLEAR
  - 4E → (2,0) (−); 26 → (2,1) 3; 36 → (2,2) 6; 46 → (2,3) 9
  - 49 → (3,0) .; 1E → (3,1) 2; 2E → (3,2) 5; 3E → (3,3) 8
  - 45 → (4,0) 0; 16 → (4,1) 1; 25 → (4,2) 4; 3D → (4,3) 7; 41 → (4,4) ,
  - 14 → (5,7) ALPHA (left ctrl)
  - 05 → (6,4) Y=; 06 → (6,3) WINDOW; 04 → (6,2) ZOOM; 0C → (6,1) TRACE; 03 → (6,0) GRAPH
  - 12 → (6,5) 2nd (left shift); 66 → (6,7) DEL
  - 07 → ON key (F12), separate from the matrix
- on_key follows the ON press/release state. on_edge=1 for exactly the one cycle after the edge where on_key goes 0→1. Repeated make codes while ON is held do not re-pulse.
- any_key is registered: the OR of all matrix bits.
- grp_we: latch grp_mask and load the counter with SETTLE_CYCLES.
  - A grp_we while busy restarts the count from SETTLE_CYCLES.
- Counter decrements by 1 per cycle while nonzero. key_busy = (counter != 0), registered.
- key_data (registered each edge):
  - If counter != 0 (including the edge grp_we loads it): 8'hFF.
  - Otherwise: bitwise NOT of the OR over groups g with grp latch[g]=0 of row[g].
  - Mask 7'h7F gives 8'hFF.
- Latency:
  - ps2 event presented before edge N → matrix updated at N → key_data reflects it at N+1 (when not settling).
  - grp_we at edge N, SETTLE_CYCLES=S≥1 → key_data is FF through edge N+S → valid data at edge N+S+1.
  - grp_we with S=0 → valid data at edge N+1.
- Simultaneous ps2 event and grp_we: both take effect on the same edge.
- Multiple keys held in selected groups combine by AND (active-low). No ghosting is modelled.
- Reset mid-press or mid-settle returns all state to reset values. Keys still physically held are not recovered until their next make code.

Test Plan:
- Reset, then first toggle edge already differs from 0 → no matrix change; any_key=0; key_data=FF.
- Press 1E (toggle), write mask 7'h77 (group 3), wait S+1=9 cycles → key_data=8'hFD, any_key=1. Release 1E → key_data=8'hFF.
- Write 7'h77, then read for cycles 1..8 → key_data=FF and key_busy=1. Second grp_we at cycle 4 → busy extends to cycle 12.
- Hold E0 75 (up) and 76 (CLEAR), mask 7'h7C (groups 0,1) → key_data=8'hB7. Mask 7'h7F → 8'hFF.
- Press 07 twice without release → on_edge pulses exactly once, on_key=1. Release → on_key=0.
- Assert reset mid-settle with keys held → all outputs at reset values in the same cycle. Unmapped code 1C press → no output change.
